// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
// Shared constants, helpers and types for the board's timing blocks
// (frequency meter, stopwatch pushbutton conditioning).
//
// Contents:
//   CLK_FREQ_HZ        board system clock frequency in Hz
//   width_for()        bits needed to hold a count 0..n-1 (at least 1)
//   gate_len()         clk cycles per measurement window
//   DEFAULT_GATE_BITS  gate counter width for a one-second window
//   DEFAULT_CNT_BITS   default edge counter width
//   startup_t          blanking states used after reset by sync_edge
// ---------------------------------------------------------------------------
package stopwatch_pkg;

   localparam int CLK_FREQ_HZ = 100_000_000;

   // Number of bits needed to count from 0 to n-1. A width of 0 is never
   // useful for a register, so small values are clamped to 1.
   function automatic int width_for(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // One window lasts clkfreq/gatefreq system clock cycles.
   function automatic int gate_len(input int clkfreq, input int gatefreq);
      return clkfreq / gatefreq;
   endfunction

   localparam int DEFAULT_GATE_BITS = width_for(CLK_FREQ_HZ);
   localparam int DEFAULT_CNT_BITS  = 27;

   // After reset the edge detector stays blind for three cycles while the
   // synchronizer and previous-sample register fill with real samples.
   typedef enum logic [1:0] {
      BLANK0 = 2'd0,
      BLANK1 = 2'd1,
      BLANK2 = 2'd2,
      ARMED  = 2'd3
   } startup_t;

endpackage

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Brings an asynchronous level into the clk domain through two flip-flops
// and flags its rising edges. Edge detection is suppressed for the first
// three cycles after reset so an input that is already high at reset does
// not look like a fresh edge. Also used for the stopwatch pushbuttons.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous, active-high reset
//   async_in  in   level from outside the clk domain
//   rise      out  high for one cycle per synchronized rising edge
// ---------------------------------------------------------------------------
module sync_edge
   import stopwatch_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise
);

   logic     meta;
   logic     sync;
   logic     prev;
   startup_t startup;

   // Two-stage synchronizer followed by the previous-sample register that
   // the edge compare looks back at. The first stage may go metastable; only
   // the second stage is used by logic.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= async_in;
         sync <= meta;
         prev <= sync;
      end
   end

   // Startup blanking: step through the blank states once after reset and
   // then stay armed until the next reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         startup <= BLANK0;
      end else begin
         case (startup)
            BLANK0:  startup <= BLANK1;
            BLANK1:  startup <= BLANK2;
            BLANK2:  startup <= ARMED;
            default: startup <= ARMED;
         endcase
      end
   end

   // A rising edge is a synchronized high whose previous sample was low,
   // ignored until the blanking period is over.
   assign rise = sync & ~prev & (startup == ARMED);

endmodule

// File: rtl/freq_meter.sv
// ---------------------------------------------------------------------------
// freq_meter
// Counts rising edges of an external square wave over a fixed gate window
// timed from the system clock and reports one count per window.
//
// Parameters:
//   CLKFREQ   system clock frequency in Hz
//   GATEFREQ  windows per second; a window is CLKFREQ/GATEFREQ cycles
//   GATEBITS  gate counter width, 2**GATEBITS must cover the window length
//   CNTBITS   edge counter and result width
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous, active-high reset
//   sig_in      in   signal under measurement, asynchronous to clk
//   enable      in   measurement enable (level); low discards the window
//   freq        out  rising-edge count of the last completed window
//   freq_valid  out  one-cycle strobe when freq/overflow update
//   overflow    out  last completed window saturated the edge counter
// ---------------------------------------------------------------------------
module freq_meter
   import stopwatch_pkg::*;
#(
   parameter int CLKFREQ  = CLK_FREQ_HZ,
   parameter int GATEFREQ = 1,
   parameter int GATEBITS = DEFAULT_GATE_BITS,
   parameter int CNTBITS  = DEFAULT_CNT_BITS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sig_in,
   input  logic               enable,
   output logic [CNTBITS-1:0] freq,
   output logic               freq_valid,
   output logic               overflow
);

   localparam int                 GATELEN   = gate_len(CLKFREQ, GATEFREQ);
   localparam logic [GATEBITS-1:0] GATE_LAST = GATEBITS'(GATELEN - 1);
   localparam logic [CNTBITS-1:0]  CNT_MAX   = '1;

   logic                rise;
   logic [GATEBITS-1:0] g;
   logic [CNTBITS-1:0]  count;
   logic                sat;

   logic                window_end;
   logic                at_max;
   logic [CNTBITS-1:0]  count_next;
   logic                sat_next;

   sync_edge u_sync_edge (
      .clk      (clk),
      .rst      (rst),
      .async_in (sig_in),
      .rise     (rise)
   );

   // Next edge-count value including this cycle's edge. The counter sticks
   // at its maximum and remembers that an edge was lost, so the window end
   // can report both the saturated count and the overflow in one step.
   assign window_end = enable && (g == GATE_LAST);
   assign at_max     = (count == CNT_MAX);
   assign count_next = (rise && !at_max) ? count + CNTBITS'(1) : count;
   assign sat_next   = sat | (rise & at_max);

   // Gate timing, edge accumulation and result registers. Dropping enable
   // throws the partial window away; the next window starts on the first
   // enabled cycle. Results only change together with freq_valid, and reset
   // takes priority over a window end in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         g          <= '0;
         count      <= '0;
         sat        <= 1'b0;
         freq       <= '0;
         overflow   <= 1'b0;
         freq_valid <= 1'b0;
      end else begin
         freq_valid <= 1'b0;
         if (!enable) begin
            g     <= '0;
            count <= '0;
            sat   <= 1'b0;
         end else if (window_end) begin
            freq       <= count_next;
            overflow   <= sat_next;
            freq_valid <= 1'b1;
            g          <= '0;
            count      <= '0;
            sat        <= 1'b0;
         end else begin
            g     <= g + GATEBITS'(1);
            count <= count_next;
            sat   <= sat_next;
         end
      end
   end

endmodule

// File: tb/tb_freq_meter.sv
// ---------------------------------------------------------------------------
// tb_freq_meter
// Drives two freq_meter instances (27-bit and 3-bit edge counters, both with
// a 100-cycle window) from shared stimulus. A window-level reference model
// turns each applied cycle into expected events queued for a monitor that
// checks the outputs on every falling clock edge.
// ---------------------------------------------------------------------------
module tb_freq_meter;

   localparam int CLKF  = 1000;
   localparam int GATEF = 10;
   localparam int GLEN  = CLKF / GATEF;
   localparam int HIST  = 16384;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sig_in = 1'b0;
   logic        enable = 1'b0;

   logic [26:0] freq_a;
   logic        valid_a;
   logic        ovf_a;
   logic [2:0]  freq_b;
   logic        valid_b;
   logic        ovf_b;

   freq_meter #(.CLKFREQ(CLKF), .GATEFREQ(GATEF), .GATEBITS(7), .CNTBITS(27)) dut_a (
      .clk        (clk),
      .rst        (rst),
      .sig_in     (sig_in),
      .enable     (enable),
      .freq       (freq_a),
      .freq_valid (valid_a),
      .overflow   (ovf_a)
   );

   freq_meter #(.CLKFREQ(CLKF), .GATEFREQ(GATEF), .GATEBITS(7), .CNTBITS(3)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .sig_in     (sig_in),
      .enable     (enable),
      .freq       (freq_b),
      .freq_valid (valid_b),
      .overflow   (ovf_b)
   );

   always #5 clk = ~clk;

   // Cycle index: during the interval after the n-th rising edge, cyc == n.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected events, ordered by the cycle in which they become visible.
   typedef struct {
      int due;
      bit is_rst;
      int id;
      int f;
      bit o;
   } ev_t;
   ev_t evq[$];

   int n_vec = 0;
   int n_bad = 0;

   // Reference model state: sampled input history, last reset edge and one
   // window accumulator per instance.
   bit hist [0:HIST-1];
   int last_rst = 0;
   int win_pos [2];
   int win_cnt [2];
   bit win_sat [2];
   int cnt_max [2] = '{134217727, 7};

   // Monitor state: result currently shown on each instance's outputs.
   bit armed = 1'b0;
   int held_f [2] = '{0, 0};
   bit held_o [2] = '{1'b0, 1'b0};

   int ph = 0;
   bit en_lvl = 1'b1;

   // One comparison; X/Z on the DUT side counts as a miscompare.
   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Window-level model for the clock edge q. An input rise is the step from
   // a low sample to a high sample, both taken after reset; it is seen two
   // edges after the high sample. Each enabled edge advances the window; the
   // last edge of a window produces a result that includes its own rise.
   task automatic modelStep(input int q, input bit r, input bit e, input bit s);
      bit edge_seen;
      hist[q] = s;
      if (r) begin
         last_rst = q;
         for (int id = 0; id < 2; id++) begin
            win_pos[id] = 0;
            win_cnt[id] = 0;
            win_sat[id] = 1'b0;
         end
         evq.push_back('{due: q, is_rst: 1'b1, id: 0, f: 0, o: 1'b0});
      end else begin
         edge_seen = (q >= last_rst + 4) && hist[q-2] && !hist[q-3];
         for (int id = 0; id < 2; id++) begin
            if (!e) begin
               win_pos[id] = 0;
               win_cnt[id] = 0;
               win_sat[id] = 1'b0;
            end else begin
               if (edge_seen) begin
                  if (win_cnt[id] == cnt_max[id]) win_sat[id] = 1'b1;
                  else win_cnt[id]++;
               end
               if (win_pos[id] == GLEN - 1) begin
                  evq.push_back('{due: q, is_rst: 1'b0, id: id, f: win_cnt[id], o: win_sat[id]});
                  win_pos[id] = 0;
                  win_cnt[id] = 0;
                  win_sat[id] = 1'b0;
               end else begin
                  win_pos[id]++;
               end
            end
         end
      end
   endtask

   // Drive one cycle of inputs on the falling edge and tell the model.
   task automatic applyStimulus(input bit r, input bit e, input bit s);
      @(negedge clk);
      rst    = r;
      enable = e;
      sig_in = s;
      modelStep(cyc + 1, r, e, s);
   endtask

   task automatic doReset(input int n, input bit s);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, s);
   endtask

   task automatic runWave(input int n, input int per, input int hi, input bit e);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, e, (ph % per) < hi);
         ph++;
      end
   endtask

   // Retire the events due now, then check strobe and held values.
   task automatic checkOutput();
      bit ev_now [2];
      ev_t e;
      int  c;
      c = cyc;
      ev_now[0] = 1'b0;
      ev_now[1] = 1'b0;
      while (evq.size() > 0 && evq[0].due <= c) begin
         e = evq.pop_front();
         if (e.is_rst) begin
            armed = 1'b1;
            held_f[0] = 0;
            held_f[1] = 0;
            held_o[0] = 1'b0;
            held_o[1] = 1'b0;
         end else begin
            held_f[e.id] = e.f;
            held_o[e.id] = e.o;
            ev_now[e.id] = 1'b1;
         end
      end
      if (armed) begin
         cmp("valid_a",    {31'd0, valid_a}, {31'd0, ev_now[0]});
         cmp("freq_a",     {5'd0, freq_a},   held_f[0]);
         cmp("overflow_a", {31'd0, ovf_a},   {31'd0, held_o[0]});
         cmp("valid_b",    {31'd0, valid_b}, {31'd0, ev_now[1]});
         cmp("freq_b",     {29'd0, freq_b},  held_f[1]);
         cmp("overflow_b", {31'd0, ovf_b},   {31'd0, held_o[1]});
      end
   endtask

   always @(negedge clk) checkOutput();

   initial begin
      $display("[TB] freq_meter bench start, window %0d cycles", GLEN);

      // Period 10 from a low phase: 10 per window; 3-bit instance saturates.
      doReset(3, 1'b0);
      ph = 5;
      runWave(300, 10, 5, 1'b1);

      // Slower wave: 2 edges per full window, no overflow on either.
      runWave(200, 50, 25, 1'b1);

      // Enable dropped 50 cycles into a window for 20 cycles.
      runWave(50, 10, 5, 1'b1);
      runWave(20, 10, 5, 1'b0);
      runWave(150, 10, 5, 1'b1);

      // Input high through and after reset: no spurious edge.
      doReset(3, 1'b1);
      runWave(120, 1, 1, 1'b1);

      // Single edge seen on the last cycle of the window, then one later.
      doReset(2, 1'b0);
      for (int i = 0; i < 210; i++) applyStimulus(1'b0, 1'b1, i >= 97);
      doReset(2, 1'b0);
      for (int i = 0; i < 210; i++) applyStimulus(1'b0, 1'b1, i >= 98);

      // Reset pulse 60 cycles into a window.
      doReset(2, 1'b0);
      ph = 0;
      runWave(60, 10, 5, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      runWave(250, 10, 5, 1'b1);

      // Random waves with occasional enable toggles and reset pulses.
      for (int seg = 0; seg < 10; seg++) begin
         int per;
         int hi;
         int len;
         per = int'($urandom_range(2, 30));
         hi  = int'($urandom_range(1, per - 1));
         len = int'($urandom_range(80, 260));
         for (int i = 0; i < len; i++) begin
            bit r;
            r = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 79) == 0) en_lvl = !en_lvl;
            applyStimulus(r, en_lvl, (ph % per) < hi);
            ph++;
         end
      end

      runWave(4, 10, 5, 1'b0);
      @(negedge clk);
      @(negedge clk);

      n_vec++;
      if (evq.size() != 0) begin
         n_bad++;
         $display("[TB] FAIL pending_events: got %0d left, expected 0", evq.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of an external square wave, the inverse of the board's clock divider: counts input rising edges over a fixed gate window timed from the 100 MHz system clock.
- Reports one result per window as an edge count with a one-cycle valid strobe.
- Used to check divided clocks on a PMOD loopback and to display measured frequency on the seven-segment display.

Parameters:
- CLKFREQ, 100_000_000, system clock frequency in Hz.
- GATEFREQ, 1, windows per second. GATELEN = CLKFREQ/GATEFREQ clk cycles per window.
- GATEBITS, 27, gate counter width. Must satisfy 2**GATEBITS >= GATELEN.
- CNTBITS, 27, edge counter and result width.

Ports:
- clk  input  1  100 MHz system clock.
- rst  input  1  synchronous, active-high reset.
- sig_in  input  1  signal under measurement; asynchronous to clk.
- enable  input  1  measurement enable; level-sensitive.
- freq  output  CNTBITS  rising-edge count of the last completed window.
- freq_valid  output  1  one-cycle pulse when freq/overflow update.
- overflow  output  1  last completed window saturated the edge counter.

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: freq=0, freq_valid=0, overflow=0. The synchronizer, edge register, gate counter, edge counter and startup counter are all 0.
- Input path: 2-FF synchronizer, then a previous-sample register. Edge = sync & ~prev. Input high and low phases must each be >= 2 clk cycles for a guaranteed count, so the maximum reliable frequency is CLKFREQ/4.
- Startup: a 2-bit startup counter blocks edge detection for the first 3 cycles after rst deasserts. This prevents a spurious edge when sig_in is already high at reset.
- Gate counter g:
  - Advances 0..GATELEN-1 on each cycle enable=1, then wraps to 0.
  - A window begins in the first cycle enable is sampled high.
  - While enable=0, g and the edge counter are held at 0, no result is produced, and the synchronizer keeps running. A partial window is discarded.
- Edge counter:
  - Increments on each qualified edge while enable=1.
  - Saturates at 2**CNTBITS-1 and sets an internal sat flag.
- Window end (g==GATELEN-1), at that clock edge:
  - freq <= count including any edge detected in that same cycle.
  - overflow <= sat (also set if this cycle's edge would overflow).
  - freq_valid <= 1 for exactly one cycle.
  - Edge counter and sat are cleared.
- Latency: with enable first high in cycle 0, freq_valid is high in cycle GATELEN, then every GATELEN cycles after that.
- freq and overflow hold their value between windows. They change only together with freq_valid.
- rst mid-window: all state returns to reset values on the next edge. No freq_valid is produced for the aborted window.
- rst and window end in the same cycle: rst wins, so freq_valid stays 0.

Decomposition:
- Package stopwatch_pkg holds:
  - the constant CLK_FREQ_HZ = 100_000_000;
  - a function gate_len(clkfreq, gatefreq);
  - a localparam-derived width helper based on $clog2.
- Sub-module sync_edge: 2-FF synchronizer plus rising-edge detect with a startup blank. It takes clk, rst, async_in and produces rise. It is reusable for the stopwatch pushbuttons.

Test Plan (CLKFREQ=1000, GATEFREQ=10, so GATELEN=100; CNTBITS=27 unless stated):
- rst, then enable=1 with sig_in period 10 clk (5 high/5 low) -> freq_valid at cycle 100, 200, 300. Each result has freq=10, overflow=0.
- sig_in held high through and after rst, enable=1 -> first result freq=0, no spurious count.
- CNTBITS=3, period 10 -> freq=7, overflow=1. Then switch to period 50 -> next full window gives freq=2, overflow=0.
- enable dropped at window cycle 50, raised 20 cycles later -> no freq_valid for the partial window. The next freq_valid comes exactly 100 cycles after the enable rise, and freq/overflow hold their prior values until then.
- Single edge whose synchronized rise falls on g==99 -> counted in that window, freq=1. An edge one cycle later is counted in the next window.
- rst pulsed for 1 cycle at window cycle 60 -> the cycle after, freq=0, overflow=0, freq_valid=0. No valid appears at the original cycle-100 boundary, and the first new result comes 100 enabled cycles after the post-reset window start.
